pixel_compositor: RTL

PIXEL_COMPOSITOR -- requirements
Module: pixel_compositor

---
 rtl/vga_pkg.sv | 10 +
 rtl/sync_delay.sv | 26 ++
 rtl/pixel_compositor.sv | 135 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared pixel types and constants for the VGA compositing path.
package vga_pkg;

   typedef logic [11:0] pixel_t;

   localparam pixel_t TRANSPARENT    = 12'h000;
   localparam pixel_t GRID_COLOR     = 12'hFFF;
   localparam int     GRID_MASK_BITS = 5;

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register used to keep timing signals aligned with the pixel pipeline.
module sync_delay #(
   parameter int               WIDTH     = 1,
   parameter int               DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stages [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stages[i] <= RESET_VAL;
      end else begin
         stages[0] <= d;
         for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
      end
   end

   assign q = stages[DEPTH-1];

endmodule

// File: rtl/pixel_compositor.sv
// Two-stage priority compositor of NUM_LAYERS RGB444 layers with per-frame overlap flag.
// Optional debug grid overlay enabled by defining COMPOSITOR_GRID_EN.
module pixel_compositor
   import vga_pkg::*;
#(
   parameter int     NUM_LAYERS = 4,
   parameter pixel_t BG_COLOR   = 12'h000
) (
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   input  logic [10:0]             hcount_in,
   input  logic [9:0]              vcount_in,
   input  logic                    hsync_in,
   input  logic                    vsync_in,
   input  logic                    blank_in,
   input  pixel_t [NUM_LAYERS-1:0] layer_in,
   output pixel_t                  pixel_out,
   output logic                    hsync_out,
   output logic                    vsync_out,
   output logic                    blank_out,
   output logic                    overlap_out
);

   logic [10:0] s1_hcount;
   logic [9:0]  s1_vcount;
   logic        s1_hsync;
   logic        s1_vsync;
   logic        s1_blank;
   pixel_t      s1_winner;
   logic        s1_any;
   logic        s1_multi;

   pixel_t      winner_next;
   logic        any_next;
   logic        multi_next;

   logic        prev_vsync;
   logic        overlap_acc;
   logic        vsync_fall;
   logic        overlap_hit;
   logic        unused_counts;

   sync_delay #(
      .WIDTH     (24),
      .DEPTH     (1),
      .RESET_VAL ({11'd0, 10'd0, 3'b111})
   ) stage1_delay (
      .clk   (clk_in),
      .rst_n (rst_n_in),
      .d     ({hcount_in, vcount_in, hsync_in, vsync_in, blank_in}),
      .q     ({s1_hcount, s1_vcount, s1_hsync, s1_vsync, s1_blank})
   );

   sync_delay #(
      .WIDTH     (3),
      .DEPTH     (1),
      .RESET_VAL (3'b111)
   ) stage2_delay (
      .clk   (clk_in),
      .rst_n (rst_n_in),
      .d     ({s1_hsync, s1_vsync, s1_blank}),
      .q     ({hsync_out, vsync_out, blank_out})
   );

   // Scan from lowest priority upward so the last opaque layer seen is the winner.
   always_comb begin
      winner_next = TRANSPARENT;
      any_next    = 1'b0;
      multi_next  = 1'b0;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (layer_in[i] != TRANSPARENT) begin
            if (any_next) multi_next = 1'b1;
            any_next    = 1'b1;
            winner_next = layer_in[i];
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         s1_winner <= TRANSPARENT;
         s1_any    <= 1'b0;
         s1_multi  <= 1'b0;
      end else begin
         s1_winner <= winner_next;
         s1_any    <= any_next;
         s1_multi  <= multi_next;
      end
   end

`ifdef COMPOSITOR_GRID_EN
   logic grid_hit;
   assign grid_hit = (s1_hcount[GRID_MASK_BITS-1:0] == '0) ||
                     (s1_vcount[GRID_MASK_BITS-1:0] == '0);
`endif

   assign unused_counts = ^{s1_hcount, s1_vcount};

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         pixel_out <= TRANSPARENT;
      end else if (s1_blank) begin
         pixel_out <= TRANSPARENT;
`ifdef COMPOSITOR_GRID_EN
      end else if (grid_hit) begin
         pixel_out <= GRID_COLOR;
`endif
      end else if (s1_any) begin
         pixel_out <= s1_winner;
      end else begin
         pixel_out <= BG_COLOR;
      end
   end

   assign vsync_fall  = prev_vsync & ~s1_vsync;
   assign overlap_hit = s1_multi & ~s1_blank;

   // A hit on the falling-edge cycle itself belongs to the new frame's accumulator.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         prev_vsync  <= 1'b1;
         overlap_acc <= 1'b0;
         overlap_out <= 1'b0;
      end else begin
         prev_vsync <= s1_vsync;
         if (vsync_fall) begin
            overlap_out <= overlap_acc;
            overlap_acc <= overlap_hit;
         end else begin
            overlap_acc <= overlap_acc | overlap_hit;
         end
      end
   end

endmodule
